// File: rtl/qpsk_frame_assembler.sv
// Collects 2-bit QPSK hard decisions into 28-bit coded frames, LSB symbol first,
// and presents each completed frame on a valid/ready output port.
module qpsk_frame_assembler #(
  parameter int SYM_W          = 2,
  parameter int SYMS_PER_FRAME = 14
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              sym_valid,
  input  logic [SYM_W-1:0]                  sym_data,
  output logic                              sym_ready,
  output logic                              frame_valid,
  output logic [SYM_W*SYMS_PER_FRAME-1:0]   frame_data,
  input  logic                              frame_ready,
  output logic [3:0]                        sym_idx,
  output logic [7:0]                        frame_cnt
);

  localparam int         FRAME_W  = SYM_W * SYMS_PER_FRAME;
  localparam logic [3:0] LAST_IDX = 4'(SYMS_PER_FRAME - 1);
  localparam logic [3:0] FULL_IDX = 4'(SYMS_PER_FRAME);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t               state, state_next;
  logic [FRAME_W-1:0]   asm_data, asm_next;
  logic [FRAME_W-1:0]   frame_data_next;
  logic                 frame_valid_next;
  logic [3:0]           sym_idx_next;
  logic [7:0]           frame_cnt_next;
  logic                 accept, deliver, slot_free;

  // sym_ready is a pure function of the registered state, never of frame_ready
  assign sym_ready = (state == COLLECT);
  assign accept    = sym_valid && sym_ready;
  assign deliver   = frame_valid && frame_ready;
  assign slot_free = !frame_valid || frame_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= COLLECT;
      asm_data    <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      sym_idx     <= '0;
      frame_cnt   <= '0;
    end else begin
      state       <= state_next;
      asm_data    <= asm_next;
      frame_data  <= frame_data_next;
      frame_valid <= frame_valid_next;
      sym_idx     <= sym_idx_next;
      frame_cnt   <= frame_cnt_next;
    end
  end

  always_comb begin
    state_next       = state;
    asm_next         = asm_data;
    frame_data_next  = frame_data;
    frame_valid_next = frame_valid && !frame_ready;
    sym_idx_next     = sym_idx;
    frame_cnt_next   = deliver ? frame_cnt + 8'd1 : frame_cnt;

    case (state)
      COLLECT: begin
        if (flush) begin
          sym_idx_next = '0;
        end else if (accept) begin
          for (int k = 0; k < SYMS_PER_FRAME; k++) begin
            if (sym_idx == 4'(k)) asm_next[SYM_W*k +: SYM_W] = sym_data;
          end
          if (sym_idx != LAST_IDX) begin
            sym_idx_next = sym_idx + 4'd1;
          end else if (slot_free) begin
            // completed frame bypasses asm so the next frame starts with no bubble
            frame_data_next  = asm_next;
            frame_valid_next = 1'b1;
            sym_idx_next     = '0;
          end else begin
            sym_idx_next = FULL_IDX;
            state_next   = HOLD;
          end
        end
      end
      HOLD: begin
        // flush is ignored here: the held frame is complete and must be delivered
        if (slot_free) begin
          frame_data_next  = asm_data;
          frame_valid_next = 1'b1;
          sym_idx_next     = '0;
          state_next       = COLLECT;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

endmodule

// File: tb/tb_qpsk_frame_assembler.sv
// Randomized bench for qpsk_frame_assembler against a queue-based frame model.
module tb_qpsk_frame_assembler;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        sym_valid;
  logic [1:0]  sym_data;
  logic        sym_ready;
  logic        frame_valid;
  logic [27:0] frame_data;
  logic        frame_ready;
  logic [3:0]  sym_idx;
  logic [7:0]  frame_cnt;

  int checks = 0;
  int errors = 0;

  // reference model: partial frame as a symbol queue plus the output slot
  int          m_q[$];
  logic        m_valid;
  logic [27:0] m_data;
  logic [7:0]  m_cnt;

  always #5 clk = ~clk;

  qpsk_frame_assembler dut (
    .clk(clk), .rst(rst), .flush(flush),
    .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready),
    .frame_valid(frame_valid), .frame_data(frame_data), .frame_ready(frame_ready),
    .sym_idx(sym_idx), .frame_cnt(frame_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [27:0] pack_frame();
    logic [27:0] f = '0;
    for (int k = 0; k < 14; k++) f = f | (28'(m_q[k]) << (2 * k));
    return f;
  endfunction

  task automatic model_step();
    logic slot_free;
    slot_free = !m_valid || frame_ready;
    if (!rst) begin
      m_q.delete(); m_valid = 1'b0; m_data = '0; m_cnt = '0;
    end else begin
      if (m_valid && frame_ready) begin
        m_cnt++;
        m_valid = 1'b0;
      end
      if (m_q.size() == 14) begin
        if (slot_free) begin
          m_data = pack_frame(); m_valid = 1'b1; m_q.delete();
        end
      end else if (flush) begin
        m_q.delete();
      end else if (sym_valid) begin
        m_q.push_back(int'(sym_data));
        if (m_q.size() == 14 && slot_free) begin
          m_data = pack_frame(); m_valid = 1'b1; m_q.delete();
        end
      end
    end
  endtask

  // one clock: model consumes the inputs set before the edge, outputs compared #1 after
  task automatic step(input logic v, input logic [1:0] d, input logic fl, input logic fr, input logic r);
    sym_valid = v; sym_data = d; flush = fl; frame_ready = fr; rst = r;
    model_step();
    @(posedge clk);
    #1;
    check_val("sym_ready",   32'(sym_ready),   32'(m_q.size() < 14));
    check_val("frame_valid", 32'(frame_valid), 32'(m_valid));
    check_val("frame_data",  32'(frame_data),  32'(m_data));
    check_val("sym_idx",     32'(sym_idx),     32'(m_q.size()));
    check_val("frame_cnt",   32'(frame_cnt),   32'(m_cnt));
  endtask

  task automatic idle(input int n, input logic fr);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0, fr, 1'b1);
  endtask

  initial begin
    logic [7:0]  cnt0;
    logic [27:0] fa;
    int          guard;
    m_valid = 1'b0; m_data = '0; m_cnt = '0;
    sym_valid = 1'b0; sym_data = '0; flush = 1'b0; frame_ready = 1'b0; rst = 1'b0;

    // reset state
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    check_val("reset_valid", 32'(frame_valid), 32'd0);
    check_val("reset_ready", 32'(sym_ready), 32'd1);
    check_val("reset_cnt",   32'(frame_cnt), 32'd0);

    // ramp pattern k mod 4
    for (int k = 0; k < 14; k++) step(1'b1, 2'(k % 4), 1'b0, 1'b1, 1'b1);
    check_val("ramp_frame", 32'(frame_data), 32'h4E4E4E4);
    check_val("ramp_valid", 32'(frame_valid), 32'd1);
    idle(1, 1'b1);
    check_val("ramp_valid_1cyc", 32'(frame_valid), 32'd0);
    check_val("ramp_cnt", 32'(frame_cnt), 32'd1);

    // three back-to-back random frames
    for (int k = 0; k < 42; k++) begin
      step(1'b1, 2'($urandom_range(3)), 1'b0, 1'b1, 1'b1);
      check_val("stream_ready", 32'(sym_ready), 32'd1);
    end
    idle(1, 1'b1);
    check_val("stream_cnt", 32'(frame_cnt), 32'd4);

    // backpressure: frame A pending, frame of all 3s goes to HOLD
    for (int k = 0; k < 14; k++) step(1'b1, 2'($urandom_range(3)), 1'b0, 1'b0, 1'b1);
    fa = frame_data;
    for (int k = 0; k < 14; k++) step(1'b1, 2'b11, 1'b0, 1'b0, 1'b1);
    check_val("bp_ready_low", 32'(sym_ready), 32'd0);
    step(1'b1, 2'b10, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b0);
    check_val("bp_stable", 32'(frame_data), 32'(fa));
    check_val("bp_hold_idx", 32'(sym_idx), 32'd14);
    idle(1, 1'b1);
    check_val("bp_second", 32'(frame_data), 32'hFFFFFFF);
    check_val("bp_ready_back", 32'(sym_ready), 32'd1);
    idle(2, 1'b1);
    check_val("bp_cnt", 32'(frame_cnt), 32'd6);

    // flush after 5 symbols, flush cycle carries a valid symbol
    for (int k = 0; k < 5; k++) step(1'b1, 2'b10, 1'b0, 1'b1, 1'b1);
    step(1'b1, 2'b11, 1'b1, 1'b1, 1'b1);
    check_val("flush_idx", 32'(sym_idx), 32'd0);
    for (int k = 0; k < 14; k++) step(1'b1, 2'b01, 1'b0, 1'b1, 1'b1);
    check_val("flush_frame", 32'(frame_data), 32'h5555555);
    idle(1, 1'b1);

    // reset pulse during HOLD
    for (int k = 0; k < 28; k++) step(1'b1, 2'($urandom_range(3)), 1'b0, 1'b0, 1'b1);
    check_val("hold_entered", 32'(sym_ready), 32'd0);
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    check_val("rst_valid", 32'(frame_valid), 32'd0);
    check_val("rst_data",  32'(frame_data), 32'd0);
    check_val("rst_cnt",   32'(frame_cnt), 32'd0);
    for (int k = 0; k < 14; k++) step(1'b1, 2'($urandom_range(3)), 1'b0, 1'b1, 1'b1);
    check_val("post_rst_valid", 32'(frame_valid), 32'd1);
    idle(1, 1'b1);

    // 256 frames with frame_ready high: counter wraps back to start value
    cnt0 = frame_cnt;
    for (int k = 0; k < 256 * 14; k++) step(1'b1, 2'($urandom_range(3)), 1'b0, 1'b1, 1'b1);
    idle(1, 1'b1);
    check_val("wrap_cnt", 32'(frame_cnt), 32'(cnt0));

    // random mix of valid, backpressure and flush
    for (int k = 0; k < 3000; k++)
      step(($urandom_range(3) != 0), 2'($urandom_range(3)), ($urandom_range(40) == 0),
           ($urandom_range(2) != 0), 1'b1);

    // drain with a bounded wait
    guard = 0;
    while ((frame_valid || !sym_ready) && guard < 50) begin
      idle(1, 1'b1);
      guard++;
    end
    check_val("drain_timeout", 32'(guard < 50), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qpsk_frame_assembler.md
# qpsk_frame_assembler

Receive-side frame assembler for the QPSK link. It sits between the QPSK demodulator and the deinterleaver. It collects 2-bit hard-decision symbols into 28-bit coded frames, which are four Hamming(7,4) codewords after interleaving. Each completed frame is presented on a valid/ready port, so the top-level sequencer no longer steers symbols by counter. It is the counterpart of the transmit-side frame-to-symbol serializer.

## Interface
Parameters:
- SYM_W, 2, bits per QPSK symbol; fixed.
- SYMS_PER_FRAME, 14, symbols per frame. FRAME_W = SYM_W*SYMS_PER_FRAME = 28.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  reset, synchronous, active-low. 0 at a posedge resets the block.
- flush  in  1  discards the partial frame being assembled; the output register is untouched.
- sym_valid  in  1  sym_data is valid this cycle.
- sym_data  in  2  demodulated symbol.
- sym_ready  out  1  block accepts a symbol this cycle.
- frame_valid  out  1  frame_data holds a complete frame.
- frame_data  out  28  assembled frame.
- frame_ready  in  1  deinterleaver consumes the frame this cycle.
- sym_idx  out  4  number of symbols held in the partial frame, 0..14.
- frame_cnt  out  8  count of frames delivered; wraps from 255 to 0.

## Operation
- A symbol is accepted on a cycle with sym_valid && sym_ready.
- Symbol k of a frame (k=0 first) lands in frame bits [2k+1:2k], LSB first, matching the transmit order.
- Assembly register asm[27:0] and counter sym_idx.
- Output register frame_data, with frame_valid.
- A frame is delivered on a cycle with frame_valid && frame_ready; frame_cnt increments on each delivery.
- The output slot is free when !frame_valid || frame_ready.
- FSM states:
  - COLLECT
    - sym_ready=1.
    - On accept, write asm bits [2*sym_idx+1:2*sym_idx].
    - If sym_idx<13, increment sym_idx.
    - If sym_idx==13 (the 14th symbol):
      - Output slot free: load frame_data with the completed frame, including this symbol. Set frame_valid=1, sym_idx=0, stay in COLLECT.
      - Otherwise: store the symbol in asm, set sym_idx=14, go to HOLD.
  - HOLD
    - sym_ready=0.
    - When the output slot is free, move asm to frame_data, set frame_valid=1, sym_idx=0, go to COLLECT.
- frame_valid clears on delivery unless a new frame is loaded on the same cycle.
- flush, in COLLECT:
  - sym_idx=0; asm contents are don't-care.
  - A symbol accepted on the same cycle is discarded, because flush has priority.
  - frame_valid and frame_data are unaffected.
- flush, in HOLD: ignored. The held frame is complete and is still delivered.
- Once frame_valid=1, frame_data holds stable until delivery.
- Unused sym_data values do not exist; all 4 codes are legal.

## Timing
- Reset values: frame_valid=0, frame_data=0, sym_ready=1 (state COLLECT), sym_idx=0, frame_cnt=0, asm=0.
- Reset is synchronous. Asserting rst mid-frame or mid-HOLD drops any partial and pending frame at that edge; operation resumes on the first edge with rst=1.
- Latency with a free output slot:
  - 14th symbol accepted at edge N.
  - frame_valid=1 from edge N.
  - The 1st symbol of the next frame is accepted at edge N+1.
- Sustained throughput is 1 symbol per cycle when frame_ready is high continuously; there are no bubbles.
- Backpressure:
  - With frame_valid=1 and frame_ready=0, symbols 1..13 of the next frame are still accepted.
  - The 14th symbol moves the FSM to HOLD; sym_ready drops the cycle after.
  - On the delivery edge, HOLD moves asm to frame_data.
  - sym_ready returns to 1 the cycle after.
- Simultaneous delivery and a 14th-symbol completion at the same edge load the new frame; frame_valid stays 1 and frame_cnt increments.
- sym_ready depends only on state (registered), never combinationally on frame_ready.
- frame_cnt wraps from 255 to 0 without a flag.

## Test plan
- Reset, then 14 symbols sym_k = k mod 4 back-to-back with frame_ready=1.
  - frame_data=0x4E4E4E4 with frame_valid high exactly 1 cycle.
  - frame_cnt=1.
- 3 consecutive frames streamed with no idle cycles and frame_ready=1.
  - All 42 symbols accepted; sym_ready never drops.
  - frame_cnt=3.
- Backpressure: frame_ready=0 after frame 1 while a 2nd frame (all symbols 2'b11) streams.
  - sym_ready=0 after the 14th symbol; frame 1 data stable.
  - Raise frame_ready: frame 1 delivered, then 0xFFFFFFF delivered.
  - No symbol lost.
- flush after 5 symbols, then 14 symbols all 2'b01.
  - Frame = 0x5555555.
  - flush together with a valid symbol drops that symbol.
- rst=0 for 1 cycle during HOLD.
  - All outputs return to reset values and the pending frame is discarded.
  - The next 14 symbols form a correct frame.
- 256 frames delivered: frame_cnt wraps to 0; frame_data correct across the wrap.
